// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and conditions the board push-buttons.
// Each bit gets a two-flop synchronizer, a debounce counter, registered
// press/release edge pulses and an IDLE/DELAY/REPEAT auto-repeat machine that
// produces the move pulses the maze game steps on.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 40_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_move
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    logic [N_BTN-1:0] sync_p0;
    logic [N_BTN-1:0] sync_p1;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] rise;

    // Two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Registered edge detection on the debounced level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d     <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            level_d     <= btn_level;
            btn_press   <= btn_level & ~level_d;
            btn_release <= ~btn_level & level_d;
        end
    end

    // A rise seen this cycle launches the press pulse and the repeat machine together
    assign rise = btn_level & ~level_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DB_W-1:0]  db_cnt;
        logic             level_q;
        logic             move_q;
        logic             move_d;
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;
        rpt_state_t       state_q;
        rpt_state_t       state_d;

        // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (sync_p1[i] == level_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt  <= '0;
                level_q <= ~level_q;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end

        // Repeat machine state, counter and registered move pulse
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= IDLE;
                rpt_cnt_q <= '0;
                move_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
                move_q    <= move_d;
            end
        end

        // Next-state: a dropped level always returns to IDLE, with no final move
        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (rise[i]) state_d = DELAY;
                DELAY:   if (!level_q) state_d = IDLE;
                         else if (rpt_cnt_q == RD_LAST) state_d = REPEAT;
                REPEAT:  if (!level_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs: move pulse and counter update; the counter clears on every pulse so it never wraps
        always_comb begin
            move_d    = 1'b0;
            rpt_cnt_d = '0;
            case (state_q)
                IDLE: move_d = rise[i];
                DELAY: begin
                    if (level_q) begin
                        if (rpt_cnt_q == RD_LAST) move_d = 1'b1;
                        else rpt_cnt_d = rpt_cnt_q + RPT_ONE;
                    end
                end
                REPEAT: begin
                    if (level_q) begin
                        if (rpt_cnt_q == RP_LAST) move_d = 1'b1;
                        else rpt_cnt_d = rpt_cnt_q + RPT_ONE;
                    end
                end
                default: begin
                    move_d    = 1'b0;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        assign btn_level[i] = level_q;
        assign btn_move[i]  = move_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus randomized button activity,
// checked every cycle against a behavioural model of the conditioner.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_move;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_move(btn_move)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips once the last D synchronized samples all disagree with it.
    // Moves: at the press, then at press ages RD, RD+RP, RD+2RP ... while held.
    logic [N-1:0] m_ff1 = '0, m_sync = '0, m_level = '0, m_level_d = '0;
    logic [N-1:0] m_press = '0, m_release = '0, m_move = '0;
    logic [D-1:0] m_hist [N];
    int           m_age  [N];
    bit           m_held [N];

    always @(posedge clk or negedge reset_n) begin : model
        logic [D-1:0] win;
        logic         rose;
        int           a;
        if (!reset_n) begin
            m_ff1 <= '0; m_sync <= '0; m_level <= '0; m_level_d <= '0;
            m_press <= '0; m_release <= '0; m_move <= '0;
            for (int i = 0; i < N; i++) begin
                m_hist[i] <= '0; m_age[i] <= 0; m_held[i] <= 1'b0;
            end
        end else begin
            m_ff1  <= btn_raw;
            m_sync <= m_ff1;
            for (int i = 0; i < N; i++) begin
                win = {m_hist[i][D-2:0], m_sync[i]};
                m_hist[i] <= win;
                m_level[i] <= (win == {D{~m_level[i]}}) ? ~m_level[i] : m_level[i];
                rose = m_level[i] & ~m_level_d[i];
                m_press[i]   <= rose;
                m_release[i] <= ~m_level[i] & m_level_d[i];
                if (rose) begin
                    m_held[i] <= 1'b1; m_age[i] <= 0; m_move[i] <= 1'b1;
                end else if (m_held[i] && m_level[i]) begin
                    a = m_age[i] + 1;
                    m_age[i]  <= a;
                    m_move[i] <= (a >= RD) && (((a - RD) % RP) == 0);
                end else begin
                    m_held[i] <= 1'b0; m_move[i] <= 1'b0;
                end
            end
            m_level_d <= m_level;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_release);
        chk("move",    btn_move,    m_move);
    end

    // Pulse counters used by the directed scenarios
    int cnt_press [N] = '{default: 0};
    int cnt_rel   [N] = '{default: 0};
    int cnt_move  [N] = '{default: 0};
    int cnt_lvl   [N] = '{default: 0};
    int cnt_p11 = 0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            cnt_press[i] <= cnt_press[i] + int'(btn_press[i]);
            cnt_rel[i]   <= cnt_rel[i]   + int'(btn_release[i]);
            cnt_move[i]  <= cnt_move[i]  + int'(btn_move[i]);
            cnt_lvl[i]   <= cnt_lvl[i]   + int'(btn_level[i]);
        end
        if (btn_press == 5'h11) cnt_p11 <= cnt_p11 + 1;
    end

    int s_press [N];
    int s_rel   [N];
    int s_move  [N];
    int s_lvl   [N];
    int s_p11;

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            s_press[i] = cnt_press[i]; s_rel[i] = cnt_rel[i];
            s_move[i]  = cnt_move[i];  s_lvl[i] = cnt_lvl[i];
        end
        s_p11 = cnt_p11;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_level"},   btn_level,   5'h00);
        chk({tag, "_press"},   btn_press,   5'h00);
        chk({tag, "_release"}, btn_release, 5'h00);
        chk({tag, "_move"},    btn_move,    5'h00);
    endtask

    int dur [N];

    initial begin
        // Reset held with every button pressed
        btn_raw = 5'h1F;
        reset_n = 1'b0;
        idle(3);
        chk_zero_outputs("rst_hold");
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_lvl_e5", btn_level, 5'h00);
        @(negedge clk);
        chk("rst_lvl_e6", btn_level, 5'h1F);
        chk("rst_press_e6", btn_press, 5'h00);
        @(negedge clk);
        chk("rst_press_e7", btn_press, 5'h1F);
        chk("rst_move_e7", btn_move, 5'h1F);
        @(negedge clk);
        chk("rst_press_e8", btn_press, 5'h00);
        btn_raw = 5'h00;
        idle(12);

        // Bounce on button 1: high 3 cycles, low 2 cycles
        snap();
        for (int c = 0; c < 40; c++) begin
            btn_raw[1] = ((c % 5) < 3);
            @(negedge clk);
        end
        btn_raw[1] = 1'b0;
        idle(10);
        chk("bounce_level", cnt_lvl[1] - s_lvl[1], 0);
        chk("bounce_press", cnt_press[1] - s_press[1], 0);
        chk("bounce_move",  cnt_move[1] - s_move[1], 0);

        // Clean short press on button 2
        snap();
        btn_raw[2] = 1'b1;
        idle(8);
        btn_raw[2] = 1'b0;
        idle(15);
        chk("clean_press",   cnt_press[2] - s_press[2], 1);
        chk("clean_move",    cnt_move[2] - s_move[2], 1);
        chk("clean_release", cnt_rel[2] - s_rel[2], 1);
        chk("clean_level",   cnt_lvl[2] - s_lvl[2], 8);

        // Auto-repeat on button 3: level high 40 cycles -> 2 + (40-11)/5 = 7 moves
        snap();
        btn_raw[3] = 1'b1;
        idle(40);
        btn_raw[3] = 1'b0;
        idle(15);
        chk("rpt_press",   cnt_press[3] - s_press[3], 1);
        chk("rpt_move",    cnt_move[3] - s_move[3], 7);
        chk("rpt_release", cnt_rel[3] - s_rel[3], 1);

        // Simultaneous press of buttons 4 and 0
        snap();
        btn_raw = 5'b10001;
        idle(10);
        chk("simul_p11",    cnt_p11 - s_p11, 1);
        chk("simul_press4", cnt_press[4] - s_press[4], 1);
        chk("simul_press0", cnt_press[0] - s_press[0], 1);
        btn_raw = 5'h00;
        idle(12);

        // Reset while button 3 is auto-repeating, button still held after release
        btn_raw[3] = 1'b1;
        idle(25);
        #3 reset_n = 1'b0;
        #1 chk_zero_outputs("rst_mid");
        idle(2);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_lvl_e5", btn_level, 5'h00);
        @(negedge clk);
        chk("rst_mid_lvl_e6", btn_level, 5'h08);
        @(negedge clk);
        chk("rst_mid_press", btn_press, 5'h08);
        chk("rst_mid_move",  btn_move,  5'h08);
        btn_raw = 5'h00;
        idle(12);

        // Randomized activity with occasional asynchronous resets
        for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 25);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (dur[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    dur[i] = (($urandom_range(0, 3)) == 0) ? $urandom_range(1, 4)
                                                           : $urandom_range(1, 40);
                end else begin
                    dur[i]--;
                end
            end
            if ((c % 700) == 350) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        btn_raw = 5'h00;
        idle(15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Debounces and conditions the five board push-buttons (BtnC/U/R/L/D) for the maze game. Each button passes through a synchronizer, a debounce filter and a per-button press/repeat state machine. The block emits a clean level, a single-cycle press pulse, a release pulse, and an auto-repeating move pulse for held direction buttons. It sits between the raw button pins and the game logic in Top_Level, and fills the input side of the design that the VGA and SSD controllers drive on the output side.

## Interface
Parameters:
- N_BTN, 5, number of buttons; bit order {D, L, R, U, C} = [4:0]
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); must be ≥ 2
- REPEAT_DELAY, 40_000_000, cycles from accepted press to first auto-repeat move pulse; must be ≥ 2
- REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeat move pulses; must be ≥ 2

Ports:
- clk  in  1  system clock (ClkPort domain, 100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- btn_raw  in  N_BTN  raw asynchronous button pins, active-high
- btn_level  out  N_BTN  debounced button level
- btn_press  out  N_BTN  one-cycle pulse on accepted press
- btn_release  out  N_BTN  one-cycle pulse on accepted release
- btn_move  out  N_BTN  one-cycle pulse on press, then auto-repeat pulses while held

## Operation
- Synchronizer: two flops per bit, both reset to 0. sync = second flop.
- Debounce (per bit):
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears to 0 on any cycle where sync == btn_level.
  - It increments on each cycle where sync != btn_level.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, btn_level toggles on that edge and the counter clears.
  - A single-cycle glitch, or any bounce shorter than DEBOUNCE_CYCLES, never changes btn_level.
- Edge pulses:
  - btn_press[i] = 1 on the cycle after btn_level[i] rises 0→1.
  - btn_release[i] = 1 on the cycle after btn_level[i] falls 1→0.
  - Both are registered and high for exactly one cycle.
- Repeat FSM, one per bit. States: IDLE, DELAY, REPEAT.
  - IDLE: rpt counter = 0. A rise of btn_level moves to DELAY and asserts btn_move together with btn_press.
  - DELAY: rpt counter increments each cycle. At REPEAT_DELAY-1: pulse btn_move, clear the counter, go to REPEAT.
  - REPEAT: rpt counter increments. At REPEAT_PERIOD-1: pulse btn_move and clear the counter.
  - From DELAY or REPEAT, btn_level = 0 returns the FSM to IDLE immediately with the counter cleared. No btn_move is issued on that cycle.
  - rpt counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). It never wraps.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses, with no priority or masking.
- Reset (asynchronous assert, any time, mid-debounce or mid-repeat):
  - All flops, counters and outputs clear; FSMs return to IDLE.
  - A button held through reset release is treated as a new press: btn_press fires after the full debounce latency.

## Timing
- Reset values: btn_level, btn_press, btn_release and btn_move are all 0.
- Press latency: raw rising edge sampled at edge k → btn_level = 1 after edge k+DEBOUNCE_CYCLES+1 → btn_press/btn_move = 1 for exactly the following cycle.
- Release latency is identical, and btn_release is one cycle wide.
- First repeat: btn_move pulse REPEAT_DELAY cycles after the press pulse. Each later repeat follows REPEAT_PERIOD cycles after the previous one.
- Holding a button for H cycles after btn_level rises (H > REPEAT_DELAY) gives 1 + 1 + floor((H-REPEAT_DELAY-1)/REPEAT_PERIOD) move pulses in total.
- No output is combinational from btn_raw.

## Test plan
The bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Reset: hold reset_n=0 with btn_raw=5'h1F → all outputs 0. Deassert reset → btn_level=5'h1F after 6 edges, with one btn_press=5'h1F pulse.
- Bounce rejection: toggle btn_raw[1] with high intervals of 3 cycles for 40 cycles → btn_level[1], btn_press[1] and btn_move[1] stay 0.
- Clean press/release: btn_raw[2]=1 for 8 cycles, then 0 → btn_press[2] and btn_move[2] pulse once, btn_release[2] pulses once, and there are no repeats.
- Auto-repeat: hold btn_raw[3] for 40 cycles → btn_move[3] pulses at press+0, +10, +15, +20, ... Releasing mid-period stops pulses with no extra move pulse.
- Simultaneous: raise btn_raw[4] and btn_raw[0] on the same edge → btn_press=5'h11 on a single cycle.
- Reset mid-repeat: assert reset_n=0 during REPEAT → all outputs 0 at once. Release reset with the button still held → fresh press pulse after debounce latency.
